// File: rtl/glip_upscale_buf.sv
// glip_upscale_buf: packs RATIO narrow words into one wide word; the first word received lands in the MSB slice.
// Latency: out_valid rises one cycle after the last narrow slice is accepted; one narrow word per cycle sustained.
// Backpressure: while the output is stalled, RATIO-1 slices are still accepted, then in_ready drops until the output drains.
// Optional feature macro: GLIP_UPSCALE_FLUSH_EN adds the flush input and the out_fill output (partial-word emit).
module glip_upscale_buf #(
  parameter int IN_SIZE = 16,
  parameter int RATIO   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [IN_SIZE-1:0]         in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [IN_SIZE*RATIO-1:0]   out_data,
  output logic                       out_valid,
`ifdef GLIP_UPSCALE_FLUSH_EN
  input  logic                       flush,
  output logic [$clog2(RATIO+1)-1:0] out_fill,
`endif
  input  logic                       out_ready
);

  localparam int CW = $clog2(RATIO);
  localparam int FW = $clog2(RATIO+1);
  localparam int OW = IN_SIZE * RATIO;
  localparam int AW = IN_SIZE * (RATIO - 1);

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc;
  logic [OW-1:0] r_out_data;
  logic          r_out_valid;

  logic          w_accept;
  logic          w_last;
  logic          w_out_free;
  logic          w_load;
  logic [OW-1:0] w_load_data;

`ifdef GLIP_UPSCALE_FLUSH_EN
  logic [FW-1:0] r_out_fill;
  logic [FW-1:0] w_load_fill;
  logic [OW-1:0] w_acc_ext;
  logic [OW-1:0] w_partial;

  // Accumulator padded to full output width so slice k sits at the same offset as in out_data.
  assign w_acc_ext = {r_acc, {IN_SIZE{1'b0}}};
  assign out_fill  = r_out_fill;
`endif

  assign w_last     = (r_cnt == CW'(RATIO - 1));
  assign w_out_free = !r_out_valid || out_ready;
  // Only the final slice needs room in the output register; earlier slices go to the accumulator.
  assign in_ready   = !w_last || w_out_free;
  assign w_accept   = in_valid && in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;

  // Decide whether the output register loads this cycle, and with what.
  always_comb begin
    w_load      = w_accept && w_last;
    w_load_data = {r_acc, in_data};
`ifdef GLIP_UPSCALE_FLUSH_EN
    w_load_fill = FW'(RATIO);
    w_partial   = '0;
    // Slices not yet received are forced to zero so stale accumulator content never leaks out.
    for (int k = 0; k < RATIO; k++) begin
      if (CW'(k) < r_cnt) begin
        w_partial[(RATIO-1-k)*IN_SIZE +: IN_SIZE] = w_acc_ext[(RATIO-1-k)*IN_SIZE +: IN_SIZE];
      end else if ((CW'(k) == r_cnt) && w_accept) begin
        w_partial[(RATIO-1-k)*IN_SIZE +: IN_SIZE] = in_data;
      end
    end
    // A flush that coincides with a completing word just yields the normal full word.
    if (!w_load && flush && w_out_free && ((r_cnt != '0) || w_accept)) begin
      w_load      = 1'b1;
      w_load_data = w_partial;
      w_load_fill = FW'(r_cnt) + FW'(w_accept);
    end
`endif
  end

  // Slice counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      if (w_load) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_accept) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (r_cnt == CW'(k)) begin
            r_acc[(RATIO-2-k)*IN_SIZE +: IN_SIZE] <= in_data;
          end
        end
      end
    end
  end

  // Output register: loads replace (and implicitly drain) the held word; held stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef GLIP_UPSCALE_FLUSH_EN
      r_out_fill  <= '0;
`endif
    end else if (w_load) begin
      r_out_data  <= w_load_data;
      r_out_valid <= 1'b1;
`ifdef GLIP_UPSCALE_FLUSH_EN
      r_out_fill  <= w_load_fill;
`endif
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_glip_upscale_buf.sv
// tb_glip_upscale_buf: directed and randomized-stall checks of the width-up converter.
// Two instances: IN_SIZE=16/RATIO=2 and IN_SIZE=8/RATIO=4; output words checked against scoreboard queues.
// Flush behaviour is exercised only when GLIP_UPSCALE_FLUSH_EN is defined.
module tb_glip_upscale_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  d4_in;
  logic        v4_in;
  logic        r4_in;
  logic [31:0] d4_out;
  logic        v4_out;
  logic        r4_out;

`ifdef GLIP_UPSCALE_FLUSH_EN
  logic        flush16;
  logic [1:0]  fill16;
  logic        flush4;
  logic [2:0]  fill4;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] q16[$];
  logic [31:0] q4[$];
  logic        rand_rdy = 1'b0;

  glip_upscale_buf #(.IN_SIZE(16), .RATIO(2)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
`ifdef GLIP_UPSCALE_FLUSH_EN
    .flush(flush16), .out_fill(fill16),
`endif
    .out_ready(out_ready)
  );

  glip_upscale_buf #(.IN_SIZE(8), .RATIO(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_data(d4_in), .in_valid(v4_in), .in_ready(r4_in),
    .out_data(d4_out), .out_valid(v4_out),
`ifdef GLIP_UPSCALE_FLUSH_EN
    .flush(flush4), .out_fill(fill4),
`endif
    .out_ready(r4_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output-side scoreboards: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q16.size() == 0) chk("m16_unexpected", 64'(out_valid), 64'(0));
      else                 chk("m16_data", 64'(out_data), 64'(q16.pop_front()));
    end
    if (!rst && v4_out && r4_out) begin
      if (q4.size() == 0) chk("m4_unexpected", 64'(v4_out), 64'(0));
      else                chk("m4_data", 64'(d4_out), 64'(q4.pop_front()));
    end
  end

  // Random sink stalls for the loopback phase.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send16(input logic [15:0] d, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 500) begin
        chk("send16_timeout", 64'(in_ready), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] d);
    int waits;
    v4_in = 1'b1;
    d4_in = d;
    waits = 0;
    forever begin
      @(negedge clk);
      if (r4_in) break;
      waits++;
      if (waits > 500) begin
        chk("send4_timeout", 64'(r4_in), 64'(1));
        break;
      end
    end
    @(posedge clk);
    #1;
    v4_in = 1'b0;
  endtask

  initial begin
    int w;
    logic [31:0] word;
    logic [31:0] fixed[2];
    fixed[0] = 32'h12345678;
    fixed[1] = 32'h9ABCDEF0;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    d4_in = '0; v4_in = 1'b0; r4_out = 1'b1;
`ifdef GLIP_UPSCALE_FLUSH_EN
    flush16 = 1'b0; flush4 = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data",  64'(out_data),  64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst4_out_valid", 64'(v4_out), 64'(0));
    chk("rst4_in_ready",  64'(r4_in),  64'(1));

    // Streaming with sink always ready
    q16.push_back(32'hAAAABBBB);
    q16.push_back(32'hCCCCDDDD);
    send16(16'hAAAA, w); chk("stream_wait_a", 64'(w), 64'(0));
    chk("stream_no_early_out", 64'(out_valid), 64'(0));
    send16(16'hBBBB, w); chk("stream_wait_b", 64'(w), 64'(0));
    chk("stream_lat_valid", 64'(out_valid), 64'(1));
    chk("stream_lat_data",  64'(out_data),  64'(32'hAAAABBBB));
`ifdef GLIP_UPSCALE_FLUSH_EN
    chk("stream_fill", 64'(fill16), 64'(2));
`endif
    send16(16'hCCCC, w); chk("stream_wait_c", 64'(w), 64'(0));
    send16(16'hDDDD, w); chk("stream_wait_d", 64'(w), 64'(0));
    chk("stream_data2", 64'(out_data), 64'(32'hCCCCDDDD));
    repeat (2) @(posedge clk);
    #1 chk("stream_drained", 64'(out_valid), 64'(0));

    // Backpressure: one word held, one more slice absorbed, then in_ready drops
    out_ready = 1'b0;
    q16.push_back(32'h11112222);
    q16.push_back(32'h33334444);
    send16(16'h1111, w);
    send16(16'h2222, w);
    send16(16'h3333, w);
    chk("bp_in_ready_low", 64'(in_ready), 64'(0));
    chk("bp_hold_data",    64'(out_data), 64'(32'h11112222));
    in_valid = 1'b1;
    in_data  = 16'h4444;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_low",  64'(in_ready),  64'(0));
    chk("bp_still_held", 64'(out_data),  64'(32'h11112222));
    chk("bp_still_vld",  64'(out_valid), 64'(1));
    out_ready = 1'b1;
    send16(16'h4444, w);
    chk("bp_replace_data", 64'(out_data),  64'(32'h33334444));
    chk("bp_replace_vld",  64'(out_valid), 64'(1));
    repeat (2) @(posedge clk);
    #1 chk("bp_queue_empty", 64'(q16.size()), 64'(0));

    // Reset in the middle of a word discards the partial slice
    send16(16'h5555, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready",  64'(in_ready),  64'(1));
    q16.push_back(32'h66667777);
    send16(16'h6666, w);
    chk("midrst_no_out", 64'(out_valid), 64'(0));
    send16(16'h7777, w);
    chk("midrst_out_vld",  64'(out_valid), 64'(1));
    chk("midrst_out_data", 64'(out_data),  64'(32'h66667777));
    repeat (2) @(posedge clk);
    #1;

    // Loopback of downscaled wide words with random source gaps and sink stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      word = (i < 2) ? fixed[i] : $urandom;
      q16.push_back(word);
      send16(word[31:16], w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send16(word[15:0], w);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("loop_queue_empty", 64'(q16.size()), 64'(0));

    // RATIO=4 byte packing
    q4.push_back(32'h01020304);
    q4.push_back(32'h05060708);
    for (int i = 1; i <= 4; i++) send4(8'(i));
    chk("r4_vld",  64'(v4_out), 64'(1));
    chk("r4_data", 64'(d4_out), 64'(32'h01020304));
`ifdef GLIP_UPSCALE_FLUSH_EN
    chk("r4_fill", 64'(fill4), 64'(4));
`endif
    for (int i = 5; i <= 8; i++) send4(8'(i));
    chk("r4_data2", 64'(d4_out), 64'(32'h05060708));
    repeat (2) @(posedge clk);
    #1;

`ifdef GLIP_UPSCALE_FLUSH_EN
    // Partial flush, then flush with nothing accumulated
    q4.push_back(32'hA1B20000);
    send4(8'hA1);
    send4(8'hB2);
    chk("fl_no_out", 64'(v4_out), 64'(0));
    flush4 = 1'b1;
    @(posedge clk);
    #1 flush4 = 1'b0;
    chk("fl_vld",  64'(v4_out), 64'(1));
    chk("fl_data", 64'(d4_out), 64'(32'hA1B20000));
    chk("fl_fill", 64'(fill4),  64'(2));
    @(posedge clk);
    #1 chk("fl_drained", 64'(v4_out), 64'(0));
    flush4 = 1'b1;
    repeat (2) @(posedge clk);
    #1 flush4 = 1'b0;
    chk("fl_empty_ignored", 64'(v4_out), 64'(0));
    q4.push_back(32'hC3D4E5F6);
    send4(8'hC3); send4(8'hD4); send4(8'hE5); send4(8'hF6);
    chk("fl_after_data", 64'(d4_out), 64'(32'hC3D4E5F6));
    chk("fl_after_fill", 64'(fill4),  64'(4));
    repeat (2) @(posedge clk);
    #1;
`endif

    repeat (3) @(posedge clk);
    #1 chk("r4_queue_empty", 64'(q4.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
